// File: rtl/dl_state_pkg.sv
// dl_state_pkg: shared sizing helpers for the valid-tracked delay line
package dl_state_pkg;
  localparam int MIN_DEPTH = 1;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dl_dff_en_rst.sv
// dl_dff_en_rst: enabled register with synchronous active-high reset to RESET_VAL
module dl_dff_en_rst #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // reset wins over enable; otherwise hold
  always_ff @(posedge clk)
    if (rst) q <= RESET_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/dl_pipe_delay.sv
// dl_pipe_delay: valid-tracked DEPTH-stage delay line with stall, flush, taps and occupancy count
module dl_pipe_delay
  import dl_state_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit ZERO_INVALID = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     valid_in,
  input  logic [WIDTH-1:0]         d,
  output logic                     valid_out,
  output logic [WIDTH-1:0]         q,
  output logic [DEPTH-1:0]         tap_valid,
  output logic [DEPTH*WIDTH-1:0]   tap_data,
  output logic [cnt_w(DEPTH)-1:0]  count
);
  localparam int CW = cnt_w(DEPTH);
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;
  stage_t s0;
  logic en_d, en_v;
  if (DEPTH < MIN_DEPTH) begin : g_bad
    $error("dl_pipe_delay: DEPTH must be >= 1");
  end
  // data only moves on a real advance; valid bits also update on flush so they can be cleared
  assign en_d = en & ~flush;
  assign en_v = en | flush;
  // stage-0 capture value, with invalid entries optionally scrubbed to RESET_VAL
  always_comb s0 = '{valid: valid_in, data: (ZERO_INVALID && !valid_in) ? RESET_VAL : d};
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] dn;
    logic             vn;
    if (i == 0) begin : g_head
      assign dn = s0.data;
      assign vn = s0.valid & ~flush;
    end else begin : g_body
      assign dn = tap_data[(i-1)*WIDTH +: WIDTH];
      assign vn = tap_valid[i-1] & ~flush;
    end
    dl_dff_en_rst #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_data (
      .clk(clk), .rst(rst), .en(en_d), .d(dn), .q(tap_data[i*WIDTH +: WIDTH])
    );
    dl_dff_en_rst #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid (
      .clk(clk), .rst(rst), .en(en_v), .d(vn), .q(tap_valid[i])
    );
  end
  assign q         = tap_data[(DEPTH-1)*WIDTH +: WIDTH];
  assign valid_out = tap_valid[DEPTH-1];
  // occupancy tracks entries in minus the entry falling off the end
  always_ff @(posedge clk)
    if (rst || flush) count <= '0;
    else if (en) count <= count + CW'(valid_in) - CW'(tap_valid[DEPTH-1]);
endmodule

// File: tb/tb_dl_pipe_delay.sv
// tb_dl_pipe_delay: scoreboard-checked directed and random stimulus for dl_pipe_delay
module tb_dl_pipe_delay;
  localparam logic [7:0] RV  = 8'hA5;
  localparam logic [7:0] RV1 = 8'h3C;
  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } ent_t;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, flush = 1'b0, vi = 1'b0;
  logic [7:0] d = '0;
  logic vo, vo1;
  logic [7:0] q, q1, td1;
  logic [3:0] tv;
  logic [31:0] td;
  logic [2:0] cnt;
  logic [0:0] tv1, cnt1;
  ent_t m4[$];
  ent_t m1[$];
  int vec = 0;
  int err = 0;
  bit live = 1'b0;
  always #5 clk = ~clk;
  dl_pipe_delay #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV), .ZERO_INVALID(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(vi), .d(d),
    .valid_out(vo), .q(q), .tap_valid(tv), .tap_data(td), .count(cnt)
  );
  dl_pipe_delay #(.WIDTH(8), .DEPTH(1), .RESET_VAL(RV1), .ZERO_INVALID(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(vi), .d(d),
    .valid_out(vo1), .q(q1), .tap_valid(tv1), .tap_data(td1), .count(cnt1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model();
    ent_t e;
    if (rst) begin
      foreach (m4[i]) m4[i] = '{1'b0, RV};
      m1[0] = '{1'b0, RV1};
    end else if (flush) begin
      foreach (m4[i]) begin
        e = m4[i];
        e.v = 1'b0;
        m4[i] = e;
      end
      e = m1[0];
      e.v = 1'b0;
      m1[0] = e;
    end else if (en) begin
      m4.push_front('{vi, vi ? d : RV});
      void'(m4.pop_back());
      m1.push_front('{vi, d});
      void'(m1.pop_back());
    end
  endtask
  task automatic check_all();
    logic [31:0] etd;
    logic [3:0] etv;
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      etd[i*8 +: 8] = m4[i].d;
      etv[i] = m4[i].v;
      n += int'(m4[i].v);
    end
    chk("tap_data", td, etd);
    chk("tap_valid", {28'b0, tv}, {28'b0, etv});
    chk("count", {29'b0, cnt}, n);
    chk("q", {24'b0, q}, {24'b0, m4[3].d});
    chk("valid_out", {31'b0, vo}, {31'b0, m4[3].v});
    chk("d1_q", {24'b0, q1}, {24'b0, m1[0].d});
    chk("d1_taps", {23'b0, tv1, td1}, {23'b0, m1[0].v, m1[0].d});
    chk("d1_valid_out", {31'b0, vo1}, {31'b0, m1[0].v});
    chk("d1_count", {31'b0, cnt1}, {31'b0, m1[0].v});
  endtask
  task automatic step(input logic r, input logic f, input logic e, input logic v, input logic [7:0] dd);
    rst = r;
    flush = f;
    en = e;
    vi = v;
    d = dd;
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask
  always @(negedge clk)
    if (live) begin
      vec++;
      assert (cnt === 3'($countones(tv)) && cnt1 === tv1) else begin
        err++;
        $error("FAIL count_invariant observed=%0d/%0d expected=%0d/%0d", cnt, cnt1, $countones(tv), tv1);
      end
    end
  initial begin
    repeat (4) m4.push_back('{1'b0, RV});
    m1.push_back('{1'b0, RV1});
    step(1, 0, 1, 1, 8'hFF);
    step(1, 0, 1, 1, 8'hFF);
    live = 1'b1;
    chk("rst_taps", td, 32'hA5A5A5A5);
    chk("rst_count", {29'b0, cnt}, 0);
    chk("rst_q1", {24'b0, q1}, {24'b0, RV1});
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 1, 1, 8'(i));
      if (i == 4) chk("latency_first", {23'b0, vo, q}, {23'b0, 1'b1, 8'd1});
    end
    chk("stream_count", {29'b0, cnt}, 4);
    step(0, 0, 1, 1, 8'h07);
    repeat (3) step(0, 0, 0, 1, 8'hEE);
    chk("stall_tap0", {24'b0, td[7:0]}, 32'h07);
    repeat (3) step(0, 0, 1, 0, 8'h00);
    chk("stall_latency", {23'b0, vo, q}, {23'b0, 1'b1, 8'h07});
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h0A);
    step(0, 0, 1, 1, 8'h0B);
    step(0, 0, 1, 1, 8'h0C);
    chk("pre_flush_count", {29'b0, cnt}, 3);
    step(0, 1, 1, 1, 8'h09);
    chk("flush_valid", {28'b0, tv}, 0);
    chk("flush_tap0", {24'b0, td[7:0]}, 32'h0C);
    step(0, 0, 1, 1, 8'h21);
    step(0, 0, 1, 0, 8'bx);
    step(0, 0, 1, 1, 8'h23);
    step(0, 0, 1, 1, 8'h24);
    step(0, 0, 1, 0, 8'bx);
    chk("bubble_taps", td, 32'hA52324A5);
    chk("bubble_valid", {28'b0, tv}, 32'b0110);
    repeat (4) step(0, 0, 1, 1, 8'h5A);
    step(1, 1, 1, 1, 8'h66);
    chk("rst_over_flush", td, 32'hA5A5A5A5);
    chk("rst_over_flush_d1", {23'b0, tv1, td1}, {23'b0, 1'b0, RV1});
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
